// File: rtl/axi_vid_pkg.sv
// Shared definitions for the video AXI4 read path.
// Contents: FSM state encoding, fixed AXI attribute codes, and a constant
// clog2 helper used to size ARSIZE and the beat counter.
package axi_vid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_WAIT = 2'd3
    } rd_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_BUF  = 4'b0011;
    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4_frame_reader_if.sv
// AXI4 read-only bus (AR and R channels) between the frame reader and DDR.
// Parameters: AW address width, DW data width.
// Modports: master (frame reader side), slave (memory / interconnect side).
interface axi4_frame_reader_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic [3:0]    ARCACHE;
    logic [2:0]    ARPROT;
    logic [DW-1:0] RDATA;
    logic          RVALID;
    logic          RLAST;
    logic [1:0]    RRESP;
    logic          RREADY;

    modport master (
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
        input  ARREADY, RDATA, RVALID, RLAST, RRESP
    );

    modport slave (
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
        output ARREADY, RDATA, RVALID, RLAST, RRESP
    );
endinterface

// File: rtl/axi4_frame_reader.sv
// AXI4 read master that fetches one frame from DDR as fixed-length INCR bursts
// and streams the beats to the display-side FIFO, throttled by i_prog_full.
// Ports:
//   clk_100Mhz, rst      clock, synchronous active-high reset
//   frame_start          pulse: read one frame from FRAME_BASE_ADDR (IDLE only)
//   FRAME_BASE_ADDR      4 KB aligned frame base
//   axi                  AXI4 read master (AR + R channels)
//   o_data, o_valid      registered beat stream, no backpressure
//   i_prog_full          downstream FIFO cannot take another full burst
//   frame_busy           frame in progress
//   state                FSM state (debug)
//   ADDR_OFFSET          byte offset of the next burst inside the frame
//   rd_err               sticky read error flag
// Optional feature macro: RD_RESP_CHECK_EN enables RRESP / burst-length checking
// on rd_err; without it rd_err is constant 0 and RRESP is ignored.
module axi4_frame_reader
    import axi_vid_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned FRAME_BYTES    = 614400
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
    axi4_frame_reader_if.master       axi,
    output logic [AXI_DATA_WIDTH-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_prog_full,
    output logic                      frame_busy,
    output logic [1:0]                state,
    output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET,
    output logic                      rd_err
);

    localparam int unsigned AW          = AXI_ADDR_WIDTH;
    localparam int unsigned DW          = AXI_DATA_WIDTH;
    localparam int unsigned BB          = DW / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BB;
    localparam int unsigned BCNT_W      = clog2(BURST_LEN) + 1;
    localparam int unsigned PAGE_W      = 12;

    rd_state_e          state_q, state_d;
    logic [AW-PAGE_W-1:0] base_q, base_d;
    logic [AW-1:0]      offset_q, offset_d;
    logic [AW-1:0]      araddr_q, araddr_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic [DW-1:0]      data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic               err_q, err_d;

    logic               beat_c;
    logic               last_c;
    logic [AW-1:0]      next_off_c;
    logic [AW-1:0]      page_base_c;

    assign beat_c      = axi.RVALID && rready_q;
    assign last_c      = beat_c && axi.RLAST;
    assign next_off_c  = offset_q + AW'(BURST_BYTES);
    // Base is page aligned, so the low 12 address bits come from the offset alone.
    assign page_base_c = {base_q, {PAGE_W{1'b0}}};

    // Next-state, address/offset and beat counter logic.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        offset_d  = offset_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        bcnt_d    = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    base_d   = FRAME_BASE_ADDR[AW-1:PAGE_W];
                    offset_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_prog_full) begin
                    araddr_d  = page_base_c + offset_q;
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    bcnt_d    = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_c) begin
                    data_d  = axi.RDATA;
                    valid_d = 1'b1;
                    bcnt_d  = bcnt_q + BCNT_W'(1);
                end
                if (last_c) begin
                    rready_d = 1'b0;
                    if (next_off_c == AW'(FRAME_BYTES)) begin
                        offset_d = '0;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        offset_d = next_off_c;
                        // Skip WAIT when the FIFO already has room for the next burst.
                        if (!i_prog_full) begin
                            araddr_d  = page_base_c + next_off_c;
                            arvalid_d = 1'b1;
                            state_d   = ST_ADDR;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky read error detection.
    always_comb begin
`ifdef RD_RESP_CHECK_EN
        err_d = err_q;
        if (beat_c) begin
            if (axi.RRESP != RESP_OKAY) begin
                err_d = 1'b1;
            end
            if (axi.RLAST && ((bcnt_q + BCNT_W'(1)) != BCNT_W'(BURST_LEN))) begin
                err_d = 1'b1;
            end
        end
`else
        err_d = 1'b0;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            offset_q  <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            bcnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            offset_q  <= offset_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            bcnt_q    <= bcnt_d;
            err_q     <= err_d;
        end
    end

    assign axi.ARADDR  = araddr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = 3'(clog2(BB));
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARCACHE = CACHE_BUF;
    assign axi.ARPROT  = PROT_DATA;
    assign axi.RREADY  = rready_q;

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign frame_busy  = busy_q;
    assign state       = state_q;
    assign ADDR_OFFSET = offset_q;
    assign rd_err      = err_q;

    // Bits intentionally not consumed (page offset of base, RRESP when unchecked).
    logic unused_sink;
    assign unused_sink = ^{FRAME_BASE_ADDR[PAGE_W-1:0], axi.RRESP};

endmodule

// File: tb/tb_axi4_frame_reader.sv
module tb_axi4_frame_reader;
    import axi_vid_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned BL = 16;
    localparam int unsigned FB = 512;
`ifdef RD_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk_100Mhz = 1'b0;
    logic          rst;
    logic          frame_start;
    logic [AW-1:0] FRAME_BASE_ADDR;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_prog_full;
    logic          frame_busy;
    logic [1:0]    state;
    logic [AW-1:0] ADDR_OFFSET;
    logic          rd_err;

    axi4_frame_reader_if #(.AW(AW), .DW(DW)) axi ();

    axi4_frame_reader #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .BURST_LEN     (BL),
        .FRAME_BYTES   (FB)
    ) dut (
        .clk_100Mhz     (clk_100Mhz),
        .rst            (rst),
        .frame_start    (frame_start),
        .FRAME_BASE_ADDR(FRAME_BASE_ADDR),
        .axi            (axi),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_prog_full    (i_prog_full),
        .frame_busy     (frame_busy),
        .state          (state),
        .ADDR_OFFSET    (ADDR_OFFSET),
        .rd_err         (rd_err)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory-side responder and output scoreboard, all driven at the falling edge.
    int            ar_delay = 0;
    int            ar_wait  = 0;
    int            hs_count = 0;
    int            nvalid   = 0;
    int            nhold    = 0;
    int            beat     = 0;
    int            cur_hs   = 0;
    int            short_hs = -1;
    int            bad_hs   = -1;
    int            bad_beat = -1;
    int            data_seq = 0;
    int            rlen;
    bit            r_act    = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [AW-1:0] aq[$];
    logic [DW-1:0] sb[$];

    always @(negedge clk_100Mhz) begin
        if (rst) begin
            axi.ARREADY = 1'b0;
            axi.RVALID  = 1'b0;
            axi.RLAST   = 1'b0;
            axi.RRESP   = 2'b00;
            axi.RDATA   = '0;
            r_act       = 1'b0;
            ar_wait     = 0;
            sb.delete();
        end else begin
            if (o_valid) begin
                nvalid++;
                if (sb.size() == 0) chk("o_data_unexpected", 64'(o_valid), 64'd0);
                else                chk("o_data", o_data, sb.pop_front());
            end
            if (r_act) begin
                rlen        = (cur_hs == short_hs) ? BL - 1 : BL;
                axi.RVALID  = 1'b1;
                axi.RDATA   = {32'h5A5A_0000 ^ 32'(data_seq), ~32'(data_seq)};
                axi.RLAST   = (beat == rlen - 1);
                axi.RRESP   = (cur_hs == bad_hs && beat == bad_beat) ? 2'b10 : 2'b00;
                if (axi.RREADY) begin
                    sb.push_back(axi.RDATA);
                    data_seq++;
                    beat++;
                    if (axi.RLAST) r_act = 1'b0;
                end
            end else begin
                axi.RVALID = 1'b0;
                axi.RLAST  = 1'b0;
                axi.RRESP  = 2'b00;
            end
            if (ar_wait > 0) chk("arvalid_held", 64'(axi.ARVALID), 64'd1);
            if (axi.ARVALID) begin
                if (ar_wait > 0) begin
                    chk("araddr_held", 64'(axi.ARADDR), 64'(held_addr));
                    nhold++;
                end
                held_addr = axi.ARADDR;
                if (ar_wait >= ar_delay) begin
                    axi.ARREADY = 1'b1;
                    aq.push_back(axi.ARADDR);
                    hs_count++;
                    cur_hs  = hs_count;
                    r_act   = 1'b1;
                    beat    = 0;
                    ar_wait = 0;
                end else begin
                    axi.ARREADY = 1'b0;
                    ar_wait++;
                end
            end else begin
                axi.ARREADY = 1'b0;
                ar_wait     = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk_100Mhz);
    endtask

    task automatic start_frame(input logic [AW-1:0] base);
        frame_start     = 1'b1;
        FRAME_BASE_ADDR = base;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (frame_busy && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 64'(frame_busy), 64'd0);
        tick();
        tick();
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n = 0;
        while (hs_count < target && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 64'(hs_count >= target), 64'd1);
    endtask

    task automatic check_frame(input string tag, input logic [AW-1:0] base,
                               input int hs0, input int nv0, input int nexp);
        chk({tag, "_bursts"}, 64'(hs_count - hs0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (hs0 + k < aq.size()) chk({tag, "_araddr"}, 64'(aq[hs0 + k]), 64'(base + AW'(k * 128)));
        end
        chk({tag, "_beats"}, 64'(nvalid - nv0), 64'(nexp));
        chk({tag, "_offset"}, 64'(ADDR_OFFSET), 64'd0);
        chk({tag, "_state"}, 64'(state), 64'(ST_IDLE));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_arvalid"}, 64'(axi.ARVALID), 64'd0);
        chk({tag, "_rready"}, 64'(axi.RREADY), 64'd0);
        chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_busy"}, 64'(frame_busy), 64'd0);
        chk({tag, "_rd_err"}, 64'(rd_err), 64'd0);
        chk({tag, "_araddr"}, 64'(axi.ARADDR), 64'd0);
        chk({tag, "_o_data"}, o_data, 64'd0);
        chk({tag, "_offset"}, 64'(ADDR_OFFSET), 64'd0);
        chk({tag, "_state"}, 64'(state), 64'(ST_IDLE));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, nv0, nh0, n;
        rst             = 1'b1;
        frame_start     = 1'b0;
        i_prog_full     = 1'b0;
        FRAME_BASE_ADDR = '0;
        tick(); tick(); tick();
        check_reset_vals("reset");
        chk("arlen", 64'(axi.ARLEN), 64'd15);
        chk("arsize", 64'(axi.ARSIZE), 64'd3);
        chk("arburst", 64'(axi.ARBURST), 64'd1);
        chk("arcache", 64'(axi.ARCACHE), 64'd3);
        chk("arprot", 64'(axi.ARPROT), 64'd0);
        rst = 1'b0;
        tick();

        // 1: basic frame, ARREADY with ARVALID
        hs0 = hs_count; nv0 = nvalid;
        start_frame(32'h1000_0000);
        chk("t1_busy", 64'(frame_busy), 64'd1);
        chk("t1_state_wait", 64'(state), 64'(ST_WAIT));
        wait_idle("t1_done");
        check_frame("t1", 32'h1000_0000, hs0, nv0, 64);

        // 2: ARREADY delayed 5 cycles
        ar_delay = 5;
        hs0 = hs_count; nv0 = nvalid; nh0 = nhold;
        start_frame(32'h1000_0000);
        wait_idle("t2_done");
        check_frame("t2", 32'h1000_0000, hs0, nv0, 64);
        chk("t2_hold_cycles", 64'(nhold - nh0), 64'd20);
        ar_delay = 0;

        // 3: programmable-full before the second burst
        hs0 = hs_count; nv0 = nvalid;
        start_frame(32'h1000_0000);
        wait_hs(hs0 + 1, "t3_first_ar");
        i_prog_full = 1'b1;
        n = 0;
        while (state != ST_WAIT && n < 200) begin
            tick();
            n++;
        end
        chk("t3_wait_entered", 64'(state), 64'(ST_WAIT));
        for (int i = 0; i < 20; i++) begin
            chk("t3_wait_state", 64'(state), 64'(ST_WAIT));
            chk("t3_wait_arvalid", 64'(axi.ARVALID), 64'd0);
            tick();
        end
        i_prog_full = 1'b0;
        tick();
        chk("t3_issue_arvalid", 64'(axi.ARVALID), 64'd1);
        chk("t3_issue_araddr", 64'(axi.ARADDR), 64'h1000_0080);
        chk("t3_issue_state", 64'(state), 64'(ST_ADDR));
        wait_idle("t3_done");
        check_frame("t3", 32'h1000_0000, hs0, nv0, 64);

        // 4: frame_start while busy is ignored; next frame uses new base
        hs0 = hs_count; nv0 = nvalid;
        start_frame(32'h1000_0000);
        wait_hs(hs0 + 2, "t4_mid");
        start_frame(32'h3000_0000);
        chk("t4_busy_kept", 64'(frame_busy), 64'd1);
        wait_idle("t4_done");
        check_frame("t4a", 32'h1000_0000, hs0, nv0, 64);
        hs0 = hs_count; nv0 = nvalid;
        start_frame(32'h2000_0000);
        wait_idle("t4b_done");
        check_frame("t4b", 32'h2000_0000, hs0, nv0, 64);

        // 5: reset in the middle of the second burst
        hs0 = hs_count;
        start_frame(32'h1000_0000);
        n = 0;
        while (!(hs_count >= hs0 + 2 && beat >= 7) && n < 3000) begin
            tick();
            n++;
        end
        chk("t5_reached_beat7", 64'(hs_count >= hs0 + 2 && beat >= 7), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_vals("t5_rst");
        tick();
        rst = 1'b0;
        tick();
        hs0 = hs_count; nv0 = nvalid;
        start_frame(32'h1000_0000);
        wait_idle("t5_done");
        check_frame("t5", 32'h1000_0000, hs0, nv0, 64);

        // 6: bad RRESP in burst 1, short burst 2
        hs0 = hs_count; nv0 = nvalid;
        chk("t6_err_clear", 64'(rd_err), 64'd0);
        bad_hs   = hs0 + 1;
        bad_beat = 3;
        short_hs = hs0 + 2;
        start_frame(32'h1000_0000);
        wait_hs(hs0 + 2, "t6_second_ar");
        tick();
        chk("t6_err_after_bad", 64'(rd_err), 64'(EXP_ERR));
        wait_idle("t6_done");
        chk("t6_err_sticky", 64'(rd_err), 64'(EXP_ERR));
        check_frame("t6", 32'h1000_0000, hs0, nv0, 63);
        bad_hs   = -1;
        short_hs = -1;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
